// File: rtl/rr_req_arbiter_pkg.sv
// Shared definitions for the per-slave round-robin request arbiter.
package rr_req_arbiter_pkg;

  localparam int unsigned REQ_STAT_W = 2;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [REQ_STAT_W-1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RSVD = 2'b11
  } req_stat_e;

endpackage

// File: rtl/rr_req_arbiter_pick2.sv
// Two-input round-robin picker: combinational one-hot grant, registered priority pointer.
module rr_pick2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt[0] = req[0] & (~req[1] | ~prio_q);
    gnt[1] = req[1] & (~req[0] |  prio_q);
  end

  // The winner hands the tie-break to the other master; idle cycles keep it.
  always_comb begin
    prio_d = prio_q;
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/rr_req_arbiter.sv
// Per-slave request arbiter: decodes eligible masters, picks one round-robin, registers grant and forwarded fields.
module rr_req_arbiter
  import rr_req_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_no,
  input  logic [REQ_STAT_W-1:0] req_stat0,
  input  logic [REQ_STAT_W-1:0] req_stat1,
  input  logic                  sfor0,
  input  logic                  sfor1,
  input  logic                  cmd0,
  input  logic                  cmd1,
  input  logic [ADDR_W-1:0]     addr0,
  input  logic [ADDR_W-1:0]     addr1,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W-1:0]     wdata1,
  output logic                  perm0,
  output logic                  perm1,
  output logic                  cmd_to,
  output logic [ADDR_W-1:0]     addr_to,
  output logic [DATA_W-1:0]     wdata_to
);

  logic [1:0]        elig;
  logic [1:0]        gnt;

  logic              perm0_q, perm0_d;
  logic              perm1_q, perm1_d;
  logic              cmd_to_q, cmd_to_d;
  logic [ADDR_W-1:0] addr_to_q, addr_to_d;
  logic [DATA_W-1:0] wdata_to_q, wdata_to_d;

  always_comb begin
    elig[0] = (req_stat0 == ST_REQ) && (sfor0 == s_no);
    elig[1] = (req_stat1 == ST_REQ) && (sfor1 == s_no);
  end

  rr_pick2 u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (elig),
    .gnt   (gnt)
  );

  always_comb begin
    perm0_d    = 1'b0;
    perm1_d    = 1'b0;
    cmd_to_d   = 1'b0;
    addr_to_d  = '0;
    wdata_to_d = '0;
    if (gnt[0]) begin
      perm0_d    = 1'b1;
      cmd_to_d   = cmd0;
      addr_to_d  = addr0;
      wdata_to_d = wdata0;
    end else if (gnt[1]) begin
      perm1_d    = 1'b1;
      cmd_to_d   = cmd1;
      addr_to_d  = addr1;
      wdata_to_d = wdata1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perm0_q    <= 1'b0;
      perm1_q    <= 1'b0;
      cmd_to_q   <= 1'b0;
      addr_to_q  <= '0;
      wdata_to_q <= '0;
    end else begin
      perm0_q    <= perm0_d;
      perm1_q    <= perm1_d;
      cmd_to_q   <= cmd_to_d;
      addr_to_q  <= addr_to_d;
      wdata_to_q <= wdata_to_d;
    end
  end

  assign perm0    = perm0_q;
  assign perm1    = perm1_q;
  assign cmd_to   = cmd_to_q;
  assign addr_to  = addr_to_q;
  assign wdata_to = wdata_to_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed self-checking bench for rr_req_arbiter.
module tb_rr_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_no;
  logic [1:0]  req_stat0, req_stat1;
  logic        sfor0, sfor1;
  logic        cmd0, cmd1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        perm0, perm1;
  logic        cmd_to;
  logic [31:0] addr_to;
  logic [31:0] wdata_to;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_no      (s_no),
    .req_stat0 (req_stat0),
    .req_stat1 (req_stat1),
    .sfor0     (sfor0),
    .sfor1     (sfor1),
    .cmd0      (cmd0),
    .cmd1      (cmd1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .perm0     (perm0),
    .perm1     (perm1),
    .cmd_to    (cmd_to),
    .addr_to   (addr_to),
    .wdata_to  (wdata_to)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic p0, input logic p1,
                           input logic c, input logic [31:0] a, input logic [31:0] w);
    check_eq({tag, ".perm0"},    64'(perm0),    64'(p0));
    check_eq({tag, ".perm1"},    64'(perm1),    64'(p1));
    check_eq({tag, ".cmd_to"},   64'(cmd_to),   64'(c));
    check_eq({tag, ".addr_to"},  64'(addr_to),  64'(a));
    check_eq({tag, ".wdata_to"}, 64'(wdata_to), 64'(w));
  endtask

  task automatic idle_inputs();
    req_stat0 = 2'b00;
    req_stat1 = 2'b00;
    sfor0 = 1'b0;
    sfor1 = 1'b0;
  endtask

  initial begin
    logic e0, e1, g0, g1, mprio;
    rst_n  = 1'b0;
    s_no   = 1'b0;
    idle_inputs();
    cmd0   = 1'b1;
    cmd1   = 1'b0;
    addr0  = 32'h0000_000F;
    addr1  = 32'h0000_00F0;
    wdata0 = 32'h000F_0F0F;
    wdata1 = 32'h00F0_F0F0;

    #2;
    check_out("reset_state", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // single requester
    req_stat0 = 2'b01;
    tick();
    check_out("single_m0", 1'b1, 1'b0, 1'b1, 32'h0000_000F, 32'h000F_0F0F);

    // mid-cycle reset clears outputs at once
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // wrong slave
    req_stat0 = 2'b01; sfor0 = 1'b1;
    req_stat1 = 2'b01; sfor1 = 1'b1;
    tick();
    check_out("wrong_slave", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // conflict from reset (prio = 0): M0, M1, M0, M1
    sfor0 = 1'b0; sfor1 = 1'b0;
    tick(); check_out("rr_c1", 1'b1, 1'b0, 1'b1, 32'h0000_000F, 32'h000F_0F0F);
    tick(); check_out("rr_c2", 1'b0, 1'b1, 1'b0, 32'h0000_00F0, 32'h00F0_F0F0);
    tick(); check_out("rr_c3", 1'b1, 1'b0, 1'b1, 32'h0000_000F, 32'h000F_0F0F);
    tick(); check_out("rr_c4", 1'b0, 1'b1, 1'b0, 32'h0000_00F0, 32'h00F0_F0F0);

    // status/sfor sweep against a small reference model; prio is 0 here
    mprio = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int st0 = 0; st0 < 4; st0++) begin
        for (int st1 = 0; st1 < 4; st1++) begin
          for (int sf = 0; sf < 4; sf++) begin
            s_no = s[0];
            req_stat0 = 2'(st0);
            req_stat1 = 2'(st1);
            sfor0 = sf[0];
            sfor1 = sf[1];
            e0 = (st0 == 1) && (sf[0] == s[0]);
            e1 = (st1 == 1) && (sf[1] == s[0]);
            g0 = e0 && (!e1 || (mprio == 1'b0));
            g1 = e1 && (!e0 || (mprio == 1'b1));
            if (g0) mprio = 1'b1;
            else if (g1) mprio = 1'b0;
            tick();
            check_eq($sformatf("sweep_s%0d_%0d%0d_%0d.perm0", s, st0, st1, sf), 64'(perm0), 64'(g0));
            check_eq($sformatf("sweep_s%0d_%0d%0d_%0d.perm1", s, st0, st1, sf), 64'(perm1), 64'(g1));
            check_eq($sformatf("sweep_s%0d_%0d%0d_%0d.addr", s, st0, st1, sf), 64'(addr_to),
                     g0 ? 64'(addr0) : (g1 ? 64'(addr1) : 64'h0));
            check_eq($sformatf("sweep_s%0d_%0d%0d_%0d.excl", s, st0, st1, sf), 64'(perm0 & perm1), 64'h0);
          end
        end
      end
    end

    // pointer hold: M1 alone, idle 3, both -> M0
    s_no = 1'b0;
    sfor0 = 1'b0; sfor1 = 1'b0;
    req_stat0 = 2'b00; req_stat1 = 2'b01;
    tick(); check_out("hold_a_m1", 1'b0, 1'b1, 1'b0, 32'h0000_00F0, 32'h00F0_F0F0);
    req_stat1 = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick(); check_out("hold_a_idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    req_stat0 = 2'b01; req_stat1 = 2'b01;
    tick(); check_out("hold_a_both", 1'b1, 1'b0, 1'b1, 32'h0000_000F, 32'h000F_0F0F);

    // pointer hold, opposite direction: M0 alone, idle 3, both -> M1
    req_stat0 = 2'b01; req_stat1 = 2'b00;
    tick(); check_out("hold_b_m0", 1'b1, 1'b0, 1'b1, 32'h0000_000F, 32'h000F_0F0F);
    req_stat0 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick(); check_out("hold_b_idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    req_stat0 = 2'b01; req_stat1 = 2'b01;
    tick(); check_out("hold_b_both", 1'b0, 1'b1, 1'b0, 32'h0000_00F0, 32'h00F0_F0F0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_req_arbiter.md
Name: rr_req_arbiter

Overview:
Per-slave request arbiter for a 2-master / 2-slave interconnect. One instance sits in front of each slave port (identified by s_no). Each cycle it selects at most one of two masters whose pending request targets this slave, using round-robin priority on conflict. It forwards the winner's cmd/addr/wdata to the slave and returns a one-cycle permission pulse to the winning master.

Parameters:
ADDR_W, 32, address width of addr0/addr1/addr_to
DATA_W, 32, write-data width of wdata0/wdata1/wdata_to

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_no  in  1  slave index served by this instance (quasi-static strap)
req_stat0  in  2  master 0 request status
req_stat1  in  2  master 1 request status
sfor0  in  1  slave targeted by master 0 (equals addr0[ADDR_W-1])
sfor1  in  1  slave targeted by master 1
cmd0  in  1  master 0 command (1 = write, 0 = read)
cmd1  in  1  master 1 command
addr0  in  ADDR_W  master 0 address
addr1  in  ADDR_W  master 1 address
wdata0  in  DATA_W  master 0 write data
wdata1  in  DATA_W  master 1 write data
perm0  out  1  grant to master 0 (request accepted this cycle)
perm1  out  1  grant to master 1
cmd_to  out  1  forwarded command
addr_to  out  ADDR_W  forwarded address
wdata_to  out  DATA_W  forwarded write data

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- req_stat encoding: 2'b00 IDLE, 2'b01 REQ (pending, eligible), 2'b10 WAIT (in flight, not eligible), 2'b11 reserved (not eligible).
- Eligibility: elig_i = (req_stat_i == 2'b01) && (sfor_i == s_no). Decoding is combinational.
- State: a 1-bit priority pointer prio (0 = master 0 preferred).
- Grant decision, combinational from the eligibility bits and prio:
  - only elig0: choose master 0.
  - only elig1: choose master 1.
  - both eligible: choose the master indicated by prio.
  - neither: no grant.
- Registered outputs: all outputs are flops updated on the rising edge of clk, so latency is 1 cycle from inputs to perm and the forwarded fields.
  - On grant to master k: perm_k <= 1, the other perm <= 0, and cmd_to/addr_to/wdata_to <= cmd_k/addr_k/wdata_k.
  - No grant: perm0 = perm1 = 0 and cmd_to/addr_to/wdata_to <= 0.
  - perm0 and perm1 are never 1 in the same cycle.
- Pointer update: after any grant to master k, prio <= ~k. With no grant, prio holds.
  - Result: a master that was just granted loses the next tie.
  - A lone requester is granted every cycle regardless of prio.
- Reset (asynchronous assert): prio = 0, perm0 = perm1 = 0, cmd_to = 0, addr_to = 0, wdata_to = 0. Reset mid-operation drops any grant immediately. Release is synchronous to clk.
- No internal request queueing. Masters hold their request until they see perm, then move req_stat out of REQ.
- Inputs of a non-granted master are ignored. addr_to is forwarded unmodified, including the slave-select MSB.

Decomposition:
- Shared package: REQ_STAT width (2) and encodings ST_IDLE, ST_REQ, ST_WAIT, ST_RSVD; ADDR_W/DATA_W defaults.
- One natural sub-module, rr_pick2: 2-input round-robin picker holding prio, outputs a one-hot grant. The top level adds eligibility decode and the output mux/registers.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> perm0 = perm1 = 0, addr_to = 0, wdata_to = 0, cmd_to = 0 immediately; prio = 0.
- Single requester: s_no = 0, stat0 = 01, sfor0 = 0, stat1 = 00, addr0 = 0x0000000F, wdata0 = 0x000F0F0F, cmd0 = 1 -> after the next edge perm0 = 1, perm1 = 0, addr_to = 0x0000000F, wdata_to = 0x000F0F0F, cmd_to = 1.
- Wrong slave: stat0 = 01, sfor0 = 1 with s_no = 0; stat1 = 01, sfor1 = 1 -> perm0 = perm1 = 0, addr_to = 0.
- Conflict with round robin, from reset: both stat = 01, both sfor = 0, s_no = 0, held for 4 cycles -> perm sequence M0, M1, M0, M1. addr_to alternates 0x0000000F / 0x000000F0; wdata_to alternates 0x000F0F0F / 0x00F0F0F0.
- Non-eligible status: all 16 combinations of stat0/stat1 in {00,01,10,11} with all four sfor combinations -> a grant occurs only where stat = 01 and sfor = s_no; never both perms high; for a lone eligible master, prio does not change which master wins.
- Pointer hold: grant M1 alone, then idle 3 cycles, then both request -> M0 wins (prio = 0 retained through the idle cycles).
